// File: rtl/acl_axis_filter.sv
//==============================================================================
// Module   : acl_axis_filter
// Purpose  : Per-axis moving-average post-processor for packed accelerometer
//            samples, with pass-through / average / dead-zone / freeze modes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module acl_axis_filter #(
    parameter int CH         = 3,
    parameter int W          = 5,
    parameter int LOG2_DEPTH = 2,
    parameter int DEADZONE   = 1
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CH*W-1:0]     in_data,
    input  logic [1:0]          mode,
    output logic                out_valid,
    output logic [CH*W-1:0]     out_data,
    output logic [2*CH-1:0]     out_dir,
    output logic                fill_done
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int SW    = W + LOG2_DEPTH;

    localparam logic [1:0]              c_mode_pass   = 2'd0;
    localparam logic [1:0]              c_mode_avg    = 2'd1;
    localparam logic [1:0]              c_mode_dz     = 2'd2;
    localparam logic [1:0]              c_mode_freeze = 2'd3;
    localparam logic [LOG2_DEPTH:0]     c_depth       = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0]     c_last        = (LOG2_DEPTH + 1)'(DEPTH - 1);
    localparam logic signed [W-1:0]     c_dz_pos      = W'(DEADZONE);
    localparam logic signed [W-1:0]     c_dz_neg      = -c_dz_pos;

    logic [LOG2_DEPTH-1:0]  r_ptr;
    logic [LOG2_DEPTH:0]    r_cnt;

    logic                   r_s1_valid;
    logic                   r_s1_full;
    logic [CH*W-1:0]        r_s1_raw;

    logic                   r_s2_seen;
    logic                   r_s2_valid;
    logic                   r_s2_full;
    logic [CH*W-1:0]        r_s2_data;

    logic                   r_out_valid;
    logic [CH*W-1:0]        r_out_data;
    logic [2*CH-1:0]        r_out_dir;
    logic                   r_fill;

    logic [CH*W-1:0]        w_sel;
    logic [2*CH-1:0]        w_dir;

    // Shared write pointer and saturating accepted-sample count
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_full  <= 1'b0;
            r_s1_raw   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_ptr     <= r_ptr + 1'b1;
                r_s1_raw  <= in_data;
                r_s1_full <= (r_cnt >= c_last);
                if (r_cnt != c_depth) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < CH; k++) begin : g_ch
            logic signed [W-1:0]  r_hist [DEPTH];
            logic signed [SW-1:0] r_sum;
            logic signed [W-1:0]  w_new;
            logic signed [W-1:0]  w_old;
            logic signed [W-1:0]  w_raw;
            logic signed [W-1:0]  w_avg;
            logic                 w_dead;

            assign w_new  = in_data[k*W +: W];
            assign w_old  = r_hist[r_ptr];
            assign w_raw  = r_s1_raw[k*W +: W];
            // Sum is wide enough that the shifted result always fits W bits
            assign w_avg  = W'(r_sum >>> LOG2_DEPTH);
            assign w_dead = (w_avg >= c_dz_neg) && (w_avg <= c_dz_pos);

            always_ff @(posedge CLK100MHZ or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_hist[i] <= '0;
                    end
                    r_sum <= '0;
                end else if (in_valid) begin
                    r_hist[r_ptr] <= w_new;
                    r_sum         <= r_sum + SW'(w_new) - SW'(w_old);
                end
            end

            always_comb begin
                w_sel[k*W +: W] = w_avg;
                case (mode)
                    c_mode_pass: w_sel[k*W +: W] = w_raw;
                    c_mode_avg:  w_sel[k*W +: W] = w_avg;
                    c_mode_dz:   w_sel[k*W +: W] = w_dead ? '0 : w_avg;
                    default:     w_sel[k*W +: W] = w_avg;
                endcase
            end
        end
    endgenerate

    // Stage 2: mode is sampled here; freeze suppresses the output strobe only
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_s2_seen  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_full  <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s2_seen  <= r_s1_valid;
            r_s2_valid <= r_s1_valid && (mode != c_mode_freeze);
            if (r_s1_valid) begin
                r_s2_full <= r_s1_full;
                r_s2_data <= w_sel;
            end
        end
    end

    always_comb begin
        w_dir = '0;
        for (int k = 0; k < CH; k++) begin
            w_dir[2*k]     = !r_s2_data[k*W + W - 1] && (r_s2_data[k*W +: W] != '0);
            w_dir[2*k + 1] = r_s2_data[k*W + W - 1];
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_dir   <= '0;
            r_fill      <= 1'b0;
        end else begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_data <= r_s2_data;
                r_out_dir  <= w_dir;
            end
            if (r_s2_seen && r_s2_full) begin
                r_fill <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_dir   = r_out_dir;
    assign fill_done = r_fill;

endmodule

`default_nettype wire

// File: tb/tb_acl_axis_filter.sv
//==============================================================================
// Module   : tb_acl_axis_filter
// Purpose  : Directed self-checking bench for acl_axis_filter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_acl_axis_filter;

    logic        CLK100MHZ;
    logic        reset;
    logic        in_valid;
    logic [14:0] in_data;
    logic [1:0]  mode;
    logic        out_valid;
    logic [14:0] out_data;
    logic [5:0]  out_dir;
    logic        fill_done;

    int n_tests = 0;
    int n_fail  = 0;

    acl_axis_filter #(
        .CH(3), .W(5), .LOG2_DEPTH(2), .DEADZONE(1)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_dir   (out_dir),
        .fill_done (fill_done)
    );

    initial begin
        CLK100MHZ = 1'b0;
        forever #5 CLK100MHZ = ~CLK100MHZ;
    end

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [14:0] d,
                             input logic [5:0] dir, input logic f);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".dir"},   32'(out_dir),   32'(dir));
        check({tag, ".fill"},  32'(fill_done), 32'(f));
    endtask

    // One isolated sample: checks the two-edge latency and the emitted result
    task automatic send(input string tag, input logic [14:0] d, input logic [14:0] exp_d,
                        input logic [5:0] exp_dir, input logic exp_f);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        check({tag, ".lat1"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, ".lat2"}, 32'(out_valid), 32'd0);
        tick();
        check_out(tag, 1'b1, exp_d, exp_dir, exp_f);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        mode     = 2'd0;
        #1;
        check_out("por", 1'b0, 15'h0000, 6'b000000, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Pass-through: X=3, Y=-2, Z=15
        mode = 2'd0;
        send("pass", 15'h0FCF, 15'h0FCF, 6'b01_10_01, 1'b0);
        tick();
        check("pass.pulse", 32'(out_valid), 32'd0);
        check("pass.hold",  32'(out_data),  32'h0FCF);

        // Stream X=7 samples, then reset asynchronously mid-cycle
        in_valid = 1'b1;
        in_data  = 15'h1C00;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        check("mid.pre_valid", 32'(out_valid), 32'd1);
        check("mid.pre_data",  32'(out_data),  32'h1C00);
        #3;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_out("mid.async", 1'b0, 15'h0000, 6'b000000, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_out("mid.held", 1'b0, 15'h0000, 6'b000000, 1'b0);
        reset = 1'b0;

        // Average: four X=4 back-to-back, then X=0 wraps over the oldest entry
        mode     = 2'd1;
        in_valid = 1'b1;
        in_data  = 15'h1000;
        tick();
        tick();
        tick();
        check_out("avg1", 1'b1, 15'h0400, 6'b01_00_00, 1'b0);
        tick();
        check_out("avg2", 1'b1, 15'h0800, 6'b01_00_00, 1'b0);
        in_data = 15'h0000;
        tick();
        check_out("avg3", 1'b1, 15'h0C00, 6'b01_00_00, 1'b0);
        in_valid = 1'b0;
        tick();
        check_out("avg4", 1'b1, 15'h1000, 6'b01_00_00, 1'b1);
        tick();
        check_out("wrap", 1'b1, 15'h0C00, 6'b01_00_00, 1'b1);
        tick();
        check("wrap.end", 32'(out_valid), 32'd0);

        // Freeze: output holds 4 while X=0 x4 drains the history
        do_reset();
        mode = 2'd0;
        send("frz.seed", 15'h1000, 15'h1000, 6'b01_00_00, 1'b0);
        mode     = 2'd3;
        in_valid = 1'b1;
        in_data  = 15'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("frz.novalid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        check("frz.novalid", 32'(out_valid), 32'd0);
        tick();
        check_out("frz.hold", 1'b0, 15'h1000, 6'b01_00_00, 1'b1);
        mode = 2'd1;
        send("frz.resume", 15'h0000, 15'h0000, 6'b00_00_00, 1'b1);

        // Negative average floors to -1; dead-zone forces it to 0
        do_reset();
        mode = 2'd1;
        send("neg.avg", 15'h7C00, 15'h7C00, 6'b10_00_00, 1'b0);
        do_reset();
        mode = 2'd2;
        send("neg.dz", 15'h7C00, 15'h0000, 6'b00_00_00, 1'b0);
        // Sum -1+15=14 -> avg 3, outside the dead-zone
        send("dz.pass", 15'h3C00, 15'h0C00, 6'b01_00_00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
